// File: rtl/tdp_bram_pipe.sv
// True dual-port byte-writable RAM with a 1- or 2-stage registered read path,
// selectable write-port output behaviour and same-address collision tracking.
module tdp_bram_pipe #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int BYTE_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int WRITE_MODE = 0,
  localparam int AW        = $clog2(DEPTH),
  localparam int NB        = WIDTH / BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic [NB-1:0]     we_a,
  input  logic [AW-1:0]     addr_a,
  input  logic [WIDTH-1:0]  data_in_a,
  output logic [WIDTH-1:0]  data_out_a,
  output logic              valid_a,
  input  logic              en_b,
  input  logic [NB-1:0]     we_b,
  input  logic [AW-1:0]     addr_b,
  input  logic [WIDTH-1:0]  data_in_b,
  output logic [WIDTH-1:0]  data_out_b,
  output logic              valid_b,
  output logic              coll,
  output logic [15:0]       coll_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             same_addr;
  logic             hit;
  logic [NB-1:0]    wea_eff, web_eff;
  logic             en_p   [2];
  logic [NB-1:0]    we_p   [2];
  logic [AW-1:0]    addr_p [2];
  logic [WIDTH-1:0] post_p [2];
  logic [WIDTH-1:0] dout_p [2];
  logic             vld_p  [2];

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] base,
                                             input logic [WIDTH-1:0] din,
                                             input logic [NB-1:0]    we);
    logic [WIDTH-1:0] r;
    r = base;
    for (int i = 0; i < NB; i++)
      if (we[i]) r[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
    return r;
  endfunction

  // post_p is the word each address holds after this edge: B lanes first, A overrides.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path (here unconditionally)
    // so no latch can be inferred.
    same_addr = (addr_a == addr_b);
    wea_eff   = (en_a && !rst) ? we_a : '0;
    web_eff   = (en_b && !rst) ? we_b : '0;
    hit       = en_a && en_b && same_addr && ((|we_a) || (|we_b));
    post_p[0] = merge(merge(mem[addr_a], data_in_b, same_addr ? web_eff : '0),
                      data_in_a, wea_eff);
    post_p[1] = merge(merge(mem[addr_b], data_in_b, web_eff),
                      data_in_a, same_addr ? wea_eff : '0);
    en_p[0]   = en_a;
    en_p[1]   = en_b;
    we_p[0]   = we_a;
    we_p[1]   = we_b;
    addr_p[0] = addr_a;
    addr_p[1] = addr_b;
  end

  // NOTE: the array has no reset branch; contents survive rst and the RAM maps onto block memory.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every read in this edge sees pre-edge values;
    // the later A-lane assignments therefore win over B on shared lanes.
    for (int i = 0; i < NB; i++)
      if (web_eff[i]) mem[addr_b][i*BYTE_W +: BYTE_W] <= data_in_b[i*BYTE_W +: BYTE_W];
    for (int i = 0; i < NB; i++)
      if (wea_eff[i]) mem[addr_a][i*BYTE_W +: BYTE_W] <= data_in_a[i*BYTE_W +: BYTE_W];
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [WIDTH-1:0] s1_data;
    logic             s1_valid;

    // Reads and read-first writes return the pre-edge word; no-change writes leave the output alone.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= 1'b0;
        if (en_p[p]) begin
          if (we_p[p] == '0 || WRITE_MODE == 0) begin
            s1_data  <= mem[addr_p[p]];
            s1_valid <= 1'b1;
          end else if (WRITE_MODE == 1) begin
            s1_data  <= post_p[p];
            s1_valid <= 1'b1;
          end
        end
      end
    end

    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s2_data;
      logic             s2_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_data  <= s1_data;
          s2_valid <= s1_valid;
        end
      end

      assign dout_p[p] = s2_data;
      assign vld_p[p]  = s2_valid;
    end else begin : g_lat1
      assign dout_p[p] = s1_data;
      assign vld_p[p]  = s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll     <= 1'b0;
      coll_cnt <= '0;
    end else begin
      coll <= hit;
      if (hit && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
    end
  end

  assign data_out_a = dout_p[0];
  assign valid_a    = vld_p[0];
  assign data_out_b = dout_p[1];
  assign valid_b    = vld_p[1];

endmodule
